// File: rtl/vec_pipe_pkg.sv
// Shared opcode set and saturation helpers
// for the vector execute/writeback pipeline.
package vec_pipe_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_VADD = 4'd1,
        OP_VSUB = 4'd2,
        OP_VMUL = 4'd3,
        OP_VMAC = 4'd4,
        OP_VACC = 4'd5,
        OP_VCLR = 4'd6,
        OP_VST  = 4'd7,
        OP_VLD  = 4'd8
    } op_e;

    // Clamp a wide signed value into a w-bit signed range
    function automatic logic signed [63:0] sat_w(
        input logic signed [63:0] v,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Accumulator clamp shares the lane clamp rule at its own width
    function automatic logic signed [63:0] sat_acc(
        input logic signed [63:0] v,
        input int                 w
    );
        return sat_w(v, w);
    endfunction

    function automatic logic writes_rd(input logic [3:0] op);
        return op inside {OP_VADD, OP_VSUB, OP_VMUL, OP_VACC, OP_VLD};
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return op > 4'd8;
    endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// One vector lane: add/sub, fixed-point multiply,
// wide accumulator and saturation detection.
module vec_lane_alu
    import vec_pipe_pkg::*;
#(
    parameter int W    = 8,
    parameter int FRAC = W - 1,
    parameter int ACCW = 2 * W + 4,
    parameter bit SAT  = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_step,
    input  logic [3:0]   i_op,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_res,
    output logic         o_sat
);

    logic signed [ACCW-1:0] r_acc;
    logic signed [63:0]     w_a;
    logic signed [63:0]     w_b;
    logic signed [63:0]     w_acc;
    logic signed [63:0]     w_prod;
    logic signed [63:0]     w_ref;
    logic signed [63:0]     w_chk;
    logic                   w_unused_hi;

    assign w_a    = {{(64-W){i_a[W-1]}}, i_a};
    assign w_b    = {{(64-W){i_b[W-1]}}, i_b};
    assign w_acc  = {{(64-ACCW){r_acc[ACCW-1]}}, r_acc};
    assign w_prod = w_a * w_b;

    // Unclamped value (w_ref) vs delivered value (w_chk); they differ on a clamp
    always_comb begin
        w_ref = '0;
        w_chk = '0;
        case (i_op)
            OP_VADD: begin
                w_ref = w_a + w_b;
                w_chk = SAT ? sat_w(w_ref, W) : w_ref;
            end
            OP_VSUB: begin
                w_ref = w_a - w_b;
                w_chk = SAT ? sat_w(w_ref, W) : w_ref;
            end
            OP_VMUL: begin
                w_ref = w_prod >>> FRAC;
                w_chk = sat_w(w_ref, W);
            end
            OP_VMAC: begin
                w_ref = w_acc + w_prod;
                w_chk = sat_acc(w_ref, ACCW);
            end
            OP_VACC: begin
                w_ref = w_acc >>> FRAC;
                w_chk = sat_w(w_ref, W);
            end
            OP_VLD: begin
                w_ref = w_a;
                w_chk = w_a;
            end
            default: begin
                w_ref = '0;
                w_chk = '0;
            end
        endcase
    end

    assign o_res       = w_chk[W-1:0];
    assign o_sat       = (w_chk != w_ref);
    assign w_unused_hi = ^w_chk[63:ACCW];

    // Accumulator changes only as the owning op leaves X
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
        end else if (i_step) begin
            if (i_op == OP_VCLR) begin
                r_acc <= '0;
            end else if (i_op == OP_VMAC) begin
                r_acc <= w_chk[ACCW-1:0];
            end
        end
    end

endmodule

// File: rtl/vec_simd_pipe.sv
// Vector execute/writeback pipeline: operand bypass,
// X/W stage registers, store handshake and register file.
module vec_simd_pipe
    import vec_pipe_pkg::*;
#(
    parameter int  LANES = 16,
    parameter int  W     = 8,
    parameter int  NREGS = 32,
    parameter int  FRAC  = W - 1,
    parameter int  ACCW  = 2 * W + 4,
    parameter bit  SAT   = 1'b1,
    localparam int AW    = $clog2(NREGS),
    localparam int VW    = LANES * W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op,
    input  logic [AW-1:0] in_rd,
    input  logic [AW-1:0] in_rs1,
    input  logic [AW-1:0] in_rs2,
    input  logic [VW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [VW-1:0] out_data,
    output logic          sat_flag,
    output logic          illegal_flag,
    input  logic          clr_flags,
    input  logic [AW-1:0] dbg_ra,
    output logic [VW-1:0] dbg_rd
);

    logic [VW-1:0]    r_rf [NREGS];
    logic             r_xv;
    logic [3:0]       r_xop;
    logic [AW-1:0]    r_xrd;
    logic [VW-1:0]    r_xa;
    logic [VW-1:0]    r_xb;
    logic             r_wv;
    logic [AW-1:0]    r_wrd;
    logic [VW-1:0]    r_wd;
    logic             r_sat;
    logic             r_ill;

    logic             w_stall;
    logic             w_step;
    logic             w_xwr;
    logic             w_take;
    logic [VW-1:0]    w_xres;
    logic [VW-1:0]    w_rs1;
    logic [VW-1:0]    w_rs2;
    logic [LANES-1:0] w_lsat;

    assign w_stall      = r_xv && (r_xop == OP_VST) && !out_ready;
    assign w_step       = r_xv && !w_stall;
    assign w_xwr        = r_xv && writes_rd(r_xop);
    assign w_take       = in_valid && !w_stall;
    assign in_ready     = !w_stall;
    assign out_valid    = r_xv && (r_xop == OP_VST);
    assign out_data     = out_valid ? r_xa : '0;
    assign sat_flag     = r_sat;
    assign illegal_flag = r_ill;
    assign dbg_rd       = r_rf[dbg_ra];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        vec_lane_alu #(
            .W    (W),
            .FRAC (FRAC),
            .ACCW (ACCW),
            .SAT  (SAT)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .i_step (w_step),
            .i_op   (r_xop),
            .i_a    (r_xa[g*W +: W]),
            .i_b    (r_xb[g*W +: W]),
            .o_res  (w_xres[g*W +: W]),
            .o_sat  (w_lsat[g])
        );
    end

    // rs1 fetch: live X result beats W register beats the file
    always_comb begin
        w_rs1 = r_rf[in_rs1];
        if (r_wv && (r_wrd == in_rs1)) w_rs1 = r_wd;
        if (w_xwr && (r_xrd == in_rs1)) w_rs1 = w_xres;
    end

    // rs2 fetch: same priority as rs1
    always_comb begin
        w_rs2 = r_rf[in_rs2];
        if (r_wv && (r_wrd == in_rs2)) w_rs2 = r_wd;
        if (w_xwr && (r_xrd == in_rs2)) w_rs2 = w_xres;
    end

    // X stage: capture the accepted op, hold everything while a store waits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_xv  <= 1'b0;
            r_xop <= OP_NOP;
            r_xrd <= '0;
            r_xa  <= '0;
            r_xb  <= '0;
        end else if (!w_stall) begin
            r_xv  <= in_valid;
            r_xop <= in_op;
            r_xrd <= in_rd;
            r_xa  <= (in_op == OP_VLD) ? in_data : w_rs1;
            r_xb  <= w_rs2;
        end
    end

    // W stage: register the result; a held store sends a bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wv  <= 1'b0;
            r_wrd <= '0;
            r_wd  <= '0;
        end else begin
            r_wv  <= w_xwr && w_step;
            r_wrd <= r_xrd;
            r_wd  <= w_xres;
        end
    end

    // Register file write from W
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
        end else if (r_wv) begin
            r_rf[r_wrd] <= r_wd;
        end
    end

    // Sticky flags; a clear wins over a same-cycle set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sat <= 1'b0;
            r_ill <= 1'b0;
        end else if (clr_flags) begin
            r_sat <= 1'b0;
            r_ill <= 1'b0;
        end else begin
            if (w_step && (|w_lsat)) r_sat <= 1'b1;
            if (w_take && is_illegal(in_op)) r_ill <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vec_simd_pipe.sv
// Bench for vec_simd_pipe: architectural model plus
// directed vectors with literal expectations.
module tb_vec_simd_pipe;
    import vec_pipe_pkg::*;

    localparam int L  = 16;
    localparam int W  = 8;
    localparam int NR = 32;
    localparam int AW = 5;
    localparam int VW = L * W;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b1;
    logic          clr_flags = 1'b0;
    logic [3:0]    in_op     = 4'd0;
    logic [AW-1:0] in_rd     = '0;
    logic [AW-1:0] in_rs1    = '0;
    logic [AW-1:0] in_rs2    = '0;
    logic [AW-1:0] dbg_ra    = '0;
    logic [VW-1:0] in_data   = '0;

    logic          in_ready, out_valid, sat_flag, illegal_flag;
    logic [VW-1:0] out_data, dbg_rd;
    logic          rdy0, ov0, sf0, il0;
    logic [VW-1:0] od0, dr0;

    int n_chk  = 0;
    int n_err  = 0;
    int n_xfer = 0;

    logic [VW-1:0] m_reg [NR];
    longint        m_acc [L];
    bit            m_pend, m_sat, m_ill, m_psat;
    logic [VW-1:0] m_st;

    vec_simd_pipe u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .sat_flag(sat_flag), .illegal_flag(illegal_flag),
        .clr_flags(clr_flags), .dbg_ra(dbg_ra), .dbg_rd(dbg_rd)
    );

    vec_simd_pipe #(.SAT(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_data(in_data), .out_valid(ov0), .out_ready(out_ready),
        .out_data(od0), .sat_flag(sf0), .illegal_flag(il0),
        .clr_flags(clr_flags), .dbg_ra(dbg_ra), .dbg_rd(dr0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [VW-1:0] act,
                       input logic [VW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] splat(input logic [7:0] b);
        return {L{b}};
    endfunction

    function automatic longint clampv(input longint v, input int w);
        longint hi, lo;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic longint fdiv(input longint p, input longint d);
        if (p >= 0) return p / d;
        return -((-p + d - 1) / d);
    endfunction

    task automatic m_clear();
        for (int r = 0; r < NR; r++) m_reg[r] = '0;
        for (int l = 0; l < L; l++) m_acc[l] = 0;
        m_pend = 0; m_sat = 0; m_ill = 0; m_psat = 0; m_st = '0;
    endtask

    task automatic m_step();
        bit            rdy, take, wr;
        logic [VW-1:0] a, b, res;
        longint        x, y, v, c;
        rdy  = !(m_pend && !out_ready);
        take = in_valid && rdy;
        if (clr_flags) begin
            m_sat = 0;
            m_ill = 0;
        end else begin
            if (m_psat) m_sat = 1;
            if (take && in_op > 4'd8) m_ill = 1;
        end
        m_psat = 0;
        if (m_pend && out_ready) m_pend = 0;
        if (!take) return;
        a   = m_reg[in_rs1];
        b   = m_reg[in_rs2];
        res = '0;
        wr  = 0;
        if (in_op == OP_VST) begin
            m_pend = 1;
            m_st   = a;
        end
        for (int l = 0; l < L; l++) begin
            x = longint'($signed(a[l*W +: W]));
            y = longint'($signed(b[l*W +: W]));
            v = 0;
            c = 0;
            case (in_op)
                OP_VADD: begin v = x + y; c = clampv(v, W); wr = 1; end
                OP_VSUB: begin v = x - y; c = clampv(v, W); wr = 1; end
                OP_VMUL: begin v = fdiv(x * y, 128); c = clampv(v, W); wr = 1; end
                OP_VMAC: begin
                    v = m_acc[l] + x * y;
                    c = clampv(v, 20);
                    m_acc[l] = c;
                end
                OP_VACC: begin v = fdiv(m_acc[l], 128); c = clampv(v, W); wr = 1; end
                OP_VCLR: m_acc[l] = 0;
                OP_VLD: begin
                    v = longint'($signed(in_data[l*W +: W]));
                    c = v;
                    wr = 1;
                end
                default: v = 0;
            endcase
            if (c != v) m_psat = 1;
            res[l*W +: W] = c[7:0];
        end
        if (wr) m_reg[in_rd] = res;
    endtask

    // Architectural model advances on each edge
    always @(posedge clk or negedge reset) begin
        if (!reset) m_clear();
        else m_step();
    end

    always @(posedge clk) begin
        if (reset && out_valid && out_ready) n_xfer++;
    end

    // Per-cycle comparison of handshake, store and flags
    always @(negedge clk) begin
        chk("in_ready", in_ready, !(m_pend && !out_ready));
        chk("out_valid", out_valid, m_pend);
        if (m_pend) chk("out_data", out_data, m_st);
        chk("sat_flag", sat_flag, m_sat);
        chk("illegal_flag", illegal_flag, m_ill);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [3:0] op, input int rd, input int rs1,
                         input int rs2, input logic [VW-1:0] d);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = AW'(rd);
        in_rs1   = AW'(rs1);
        in_rs2   = AW'(rs2);
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_chk++;
            n_err++;
            $display("FAIL issue_timeout actual=%0d required=1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op    = 4'd0;
    endtask

    task automatic lit(input string nm, input int r, input logic [VW-1:0] exp);
        dbg_ra = AW'(r);
        #1;
        chk(nm, dbg_rd, exp);
    endtask

    task automatic chk_regs(input string nm);
        for (int r = 0; r < NR; r++) begin
            dbg_ra = AW'(r);
            #1;
            chk(nm, dbg_rd, m_reg[r]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_flags();
        clr_flags = 1'b1;
        @(posedge clk);
        #1;
        clr_flags = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        m_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sat", sat_flag, 0);
        chk("rst_ill", illegal_flag, 0);
        chk_regs("rst_regs");
        reset = 1'b1;
        idle(1);

        issue(OP_VLD, 1, 0, 0, splat(8'h10));
        issue(OP_VLD, 2, 0, 0, splat(8'h20));
        issue(OP_VADD, 3, 1, 2, '0);
        issue(OP_VADD, 4, 3, 3, '0);
        issue(OP_VSUB, 16, 1, 2, '0);
        idle(3);
        lit("fwd_r3", 3, splat(8'h30));
        lit("fwd_r4", 4, splat(8'h60));
        lit("vsub_r16", 16, splat(8'hF0));

        issue(OP_VLD, 5, 0, 0, splat(8'h70));
        issue(OP_VADD, 6, 5, 5, '0);
        idle(3);
        lit("sat_add", 6, splat(8'h7F));
        chk("wrap_add", dr0, splat(8'hE0));
        chk("sat_flag_set", sat_flag, 1);
        chk("wrap_noflag", sf0, 0);
        clear_flags();
        @(negedge clk);
        chk("sat_flag_clr", sat_flag, 0);
        idle(1);

        issue(OP_VLD, 7, 0, 0, splat(8'h80));
        issue(OP_VMUL, 8, 7, 7, '0);
        issue(OP_VLD, 9, 0, 0, splat(8'h40));
        issue(OP_VMUL, 10, 9, 9, '0);
        issue(OP_VLD, 11, 0, 0, splat(8'hC0));
        issue(OP_VMUL, 12, 11, 9, '0);
        idle(3);
        lit("vmul_80", 8, splat(8'h7F));
        lit("vmul_40", 10, splat(8'h20));
        lit("vmul_c0", 12, splat(8'hE0));
        chk("vmul_sat", sat_flag, 1);
        clear_flags();

        issue(OP_VCLR, 0, 0, 0, '0);
        repeat (2) issue(OP_VMAC, 0, 9, 9, '0);
        issue(OP_VACC, 13, 0, 0, '0);
        idle(3);
        lit("mac2", 13, splat(8'h40));
        chk("mac2_nosat", sat_flag, 0);
        issue(OP_VCLR, 0, 0, 0, '0);
        repeat (4) issue(OP_VMAC, 0, 9, 9, '0);
        issue(OP_VACC, 14, 0, 0, '0);
        idle(3);
        lit("mac4", 14, splat(8'h7F));
        chk("mac4_sat", sat_flag, 1);
        clear_flags();
        chk_regs("mid_regs");

        out_ready = 1'b0;
        issue(OP_VST, 0, 3, 0, '0);
        in_valid = 1'b1;
        in_op    = OP_VADD;
        in_rd    = AW'(15);
        in_rs1   = AW'(1);
        in_rs2   = AW'(2);
        dbg_ra   = AW'(15);
        repeat (3) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, splat(8'h30));
            chk("bp_ready", in_ready, 0);
            chk("bp_r15", dbg_rd, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op    = 4'd0;
        @(negedge clk);
        chk("bp_done", out_valid, 0);
        idle(3);
        lit("bp_r15_late", 15, splat(8'h30));
        chk("bp_xfers", n_xfer, 1);

        issue(4'hF, 3, 1, 2, '0);
        idle(3);
        chk("illegal_set", illegal_flag, 1);
        lit("illegal_r3", 3, splat(8'h30));
        chk_regs("ill_regs");

        out_ready = 1'b0;
        issue(OP_VST, 0, 4, 0, '0);
        @(negedge clk);
        chk("rs_valid_pre", out_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("rs_valid", out_valid, 0);
        chk("rs_ready", in_ready, 1);
        chk("rs_ill", illegal_flag, 0);
        chk_regs("rs_regs");
        reset     = 1'b1;
        out_ready = 1'b1;
        idle(2);
        lit("rs_r4", 4, 0);
        chk_regs("end_regs");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
